sort_out_serializer: RTL

//  Downstream stage of sort_pipe. Accepts one sorted vector of 8 lanes (valid/ready) and emits its

---
 rtl/sort_out_serializer_if.sv | 23 ++
 rtl/sort_out_serializer.sv | 113 +++++++++++
 2 files changed

// File: rtl/sort_out_serializer_if.sv
// rtl/sort_out_serializer_if.sv - vector-in / element-out handshake bundle for sort_out_serializer
interface sort_out_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                      in_val;
  logic                      in_rdy;
  logic [8*DATA_WIDTH-1:0]   in_data;
  logic                      out_val;
  logic                      out_rdy;
  logic [DATA_WIDTH-1:0]     out_data;
  logic [2:0]                out_idx;
  logic                      out_last;

  modport slave (
    input  in_val, in_data, out_rdy,
    output in_rdy, out_val, out_data, out_idx, out_last
  );

  modport master (
    output in_val, in_data, out_rdy,
    input  in_rdy, out_val, out_data, out_idx, out_last
  );
endinterface

// File: rtl/sort_out_serializer.sv
// rtl/sort_out_serializer.sv - serializes a sorted 8-lane vector, checks order, counts vectors
module sort_out_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sort_out_serializer_if.slave bus,
  input  logic                 err_clr,
  output logic                 sort_err,
  output logic [CNT_WIDTH-1:0] vec_cnt
);

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [8*DATA_WIDTH-1:0] r_vec;
  logic [2:0]              r_idx;
  logic [DATA_WIDTH-1:0]   r_prev;
  logic                    r_err;
  logic [CNT_WIDTH-1:0]    r_cnt;

  logic [DATA_WIDTH-1:0]   w_lane [8];
  logic [DATA_WIDTH-1:0]   w_cur;
  logic                    w_last;
  logic                    w_out_hs;
  logic                    w_in_rdy;
  logic                    w_in_hs;

  for (genvar k = 0; k < 8; k++) begin : g_lane
    assign w_lane[k] = r_vec[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_cur    = w_lane[r_idx];
  assign w_last   = (r_idx == 3'd7);
  assign w_out_hs = (r_state == S_SHIFT) && bus.out_rdy;
  assign w_in_hs  = bus.in_val && w_in_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_in_hs) w_next = S_SHIFT;
      S_SHIFT: if (w_out_hs && w_last) w_next = bus.in_val ? S_SHIFT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // in_rdy looks through out_rdy so the next vector loads on the final element's edge.
  always_comb begin
    w_in_rdy     = 1'b0;
    bus.out_val  = 1'b0;
    bus.out_data = '0;
    bus.out_idx  = 3'd0;
    bus.out_last = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_rdy = 1'b1;
      end
      S_SHIFT: begin
        w_in_rdy     = w_last && bus.out_rdy;
        bus.out_val  = 1'b1;
        bus.out_data = w_cur;
        bus.out_idx  = r_idx;
        bus.out_last = w_last;
      end
      default: begin
        w_in_rdy = 1'b0;
      end
    endcase
  end

  assign bus.in_rdy = w_in_rdy;

  // Loading a vector only happens in IDLE or on the idx7 handshake, so it never races the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec  <= '0;
      r_idx  <= 3'd0;
      r_prev <= '0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_in_hs) begin
        r_vec <= bus.in_data;
        r_idx <= 3'd0;
      end else if (w_out_hs && !w_last) begin
        r_idx  <= r_idx + 3'd1;
        r_prev <= w_cur;
      end
      if (w_out_hs && w_last) begin
        r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      if (w_out_hs && (r_idx != 3'd0) && (w_cur < r_prev)) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign sort_err = r_err;
  assign vec_cnt  = r_cnt;

endmodule
